// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data RAM arbiter.
// Holds the width constants shared with the CPU core, the response-owner
// encoding and the word-alignment check.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  // Which requester owns the access whose response is in flight
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // One-stage response pipeline payload
  typedef struct packed {
    owner_e owner;
    logic   was_read;
    logic   misaligned;
  } rsp_t;

  // Word access is aligned when the two byte-offset bits are zero
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, load/store port and RAM port signals.
// master: requesters + RAM model side; slave: the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
);
  // Fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;
  // Load/store port
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;
  // RAM port
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_wen;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_ack, if_rdata, if_err,
    output d_gnt, d_ack, d_rdata, d_err,
    output ram_addr, ram_wdata, ram_wen
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_ack, if_rdata, if_err,
    input  d_gnt, d_ack, d_rdata, d_err,
    input  ram_addr, ram_wdata, ram_wen
  );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// arb_starve_ctr: counts consecutive data grants while fetch waits and
// raises force_if_c once the limit is reached.
// Ports: clk, rst_n, if_req, if_gnt, d_gnt in; force_if_c out (combinational).
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_if_c
);

  // A zero limit still needs a one-bit register to stay legal
  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_limit_c;

  assign at_limit_c = (cnt_q == CW'(STARVE_LIMIT));
  assign force_if_c = (STARVE_LIMIT != 0) && at_limit_c;

  // Clear when fetch is served or stops waiting; saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (d_gnt && !at_limit_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word RAM between the
// instruction-fetch port and the load/store port. Data has fixed priority
// with a starvation guard for fetch; one access per cycle, ack one cycle
// after grant, misaligned accesses are rejected without touching the RAM.
// Ports: clk, rst_n (async, active-low), bus (slave modport: fetch port,
// load/store port, RAM port).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_W,
  parameter int unsigned DATA_WIDTH   = DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  logic                  force_if_c;
  logic                  d_gnt_c;
  logic                  if_gnt_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;
  logic                  ram_wen_c;
  rsp_t                  rsp_d;
  rsp_t                  rsp_q;

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (bus.if_req),
    .if_gnt     (if_gnt_c),
    .d_gnt      (d_gnt_c),
    .force_if_c (force_if_c)
  );

  // Grant: data first unless fetch has been starved long enough; none in reset
  always_comb begin
    d_gnt_c  = rst_n && bus.d_req && !(force_if_c && bus.if_req);
    if_gnt_c = rst_n && bus.if_req && !d_gnt_c;
  end

  // RAM drive and response-stage capture for the granted access
  always_comb begin
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    ram_wen_c   = 1'b0;
    rsp_d       = '{owner: OWN_NONE, was_read: 1'b0, misaligned: 1'b0};
    if (d_gnt_c) begin
      ram_addr_c       = bus.d_addr;
      ram_wdata_c      = bus.d_wdata;
      ram_wen_c        = bus.d_we && is_aligned(bus.d_addr[1:0]);
      rsp_d.owner      = OWN_D;
      rsp_d.was_read   = !bus.d_we;
      rsp_d.misaligned = !is_aligned(bus.d_addr[1:0]);
    end else if (if_gnt_c) begin
      ram_addr_c       = bus.if_addr;
      rsp_d.owner      = OWN_IF;
      rsp_d.was_read   = 1'b1;
      rsp_d.misaligned = !is_aligned(bus.if_addr[1:0]);
    end
  end

  // Reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '{owner: OWN_NONE, was_read: 1'b0, misaligned: 1'b0};
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.ram_wen   = ram_wen_c;

  // Route RAM read data to the owner; misaligned or write responses carry zero
  always_comb begin
    bus.if_ack   = (rsp_q.owner == OWN_IF);
    bus.if_err   = bus.if_ack && rsp_q.misaligned;
    bus.if_rdata = (bus.if_ack && !rsp_q.misaligned) ? bus.ram_rdata : '0;
    bus.d_ack    = (rsp_q.owner == OWN_D);
    bus.d_err    = bus.d_ack && rsp_q.misaligned;
    bus.d_rdata  = (bus.d_ack && rsp_q.was_read && !rsp_q.misaligned) ?
                   bus.ram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b ();
  mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) z ();

  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM model, preloaded while reset is held
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[0]      <= 32'h1111_0000;
      mem[1]      <= 32'h2222_0004;
      mem[4]      <= 32'h0000_0000;
      b.ram_rdata <= 32'h0;
    end else begin
      if (b.ram_wen) mem[b.ram_addr[11:2]] <= b.ram_wdata;
      b.ram_rdata <= mem[b.ram_addr[11:2]];
    end
  end
  assign z.ram_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        exp_d;
    logic [11:0] a;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    {b.if_req, b.d_req, b.d_we} = 3'b000;
    b.if_addr = '0; b.d_addr = '0; b.d_wdata = '0;
    {z.if_req, z.d_req, z.d_we} = 3'b000;
    z.if_addr = '0; z.d_addr = '0; z.d_wdata = '0;

    // 1. Reset: grants suppressed even with a request present
    #1 b.d_req = 1'b1; b.d_addr = 12'h010;
    #2;
    chk("rst_d_gnt", 32'(b.d_gnt), 32'h0);
    chk("rst_if_gnt", 32'(b.if_gnt), 32'h0);
    chk("rst_ram_wen", 32'(b.ram_wen), 32'h0);
    chk("rst_ram_addr", 32'(b.ram_addr), 32'h0);
    chk("rst_d_ack", 32'(b.d_ack), 32'h0);
    b.d_req = 1'b0; b.d_addr = '0;
    #19 rst_n = 1'b1;
    tick();
    chk("idle_if_ack", 32'(b.if_ack), 32'h0);
    chk("idle_d_ack", 32'(b.d_ack), 32'h0);
    chk("idle_d_rdata", b.d_rdata, 32'h0);
    chk("idle_if_rdata", b.if_rdata, 32'h0);
    chk("idle_ram_wdata", b.ram_wdata, 32'h0);

    // Reset mid-transaction drops the pending ack
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 12'h000;
    #1 chk("mid_d_gnt", 32'(b.d_gnt), 32'h1);
    tick();
    chk("mid_d_ack_pre", 32'(b.d_ack), 32'h1);
    b.d_req = 1'b0; rst_n = 1'b0;
    #1 chk("mid_d_ack_rst", 32'(b.d_ack), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_d_ack_post", 32'(b.d_ack), 32'h0);
    tick();
    chk("mid_d_ack_post2", 32'(b.d_ack), 32'h0);

    // 2. Write 0x010 then read it back the next cycle
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_addr = 12'h010; b.d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_d_gnt", 32'(b.d_gnt), 32'h1);
    chk("wr_ram_wen", 32'(b.ram_wen), 32'h1);
    chk("wr_ram_addr", 32'(b.ram_addr), 32'h010);
    chk("wr_ram_wdata", b.ram_wdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_d_ack", 32'(b.d_ack), 32'h1);
    chk("wr_d_rdata", b.d_rdata, 32'h0);
    b.d_we = 1'b0; b.d_wdata = '0;
    #1 chk("rd_ram_wen", 32'(b.ram_wen), 32'h0);
    tick();
    chk("rd_d_ack", 32'(b.d_ack), 32'h1);
    chk("rd_d_rdata", b.d_rdata, 32'hDEAD_BEEF);
    chk("rd_d_err", 32'(b.d_err), 32'h0);
    b.d_req = 1'b0;
    tick();
    chk("rd_d_ack_done", 32'(b.d_ack), 32'h0);

    // 5. Misaligned write is rejected, RAM untouched
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_addr = 12'h013; b.d_wdata = 32'h1234_5678;
    #1;
    chk("mis_d_gnt", 32'(b.d_gnt), 32'h1);
    chk("mis_ram_wen", 32'(b.ram_wen), 32'h0);
    tick();
    chk("mis_d_ack", 32'(b.d_ack), 32'h1);
    chk("mis_d_err", 32'(b.d_err), 32'h1);
    chk("mis_d_rdata", b.d_rdata, 32'h0);
    b.d_we = 1'b0; b.d_addr = 12'h010; b.d_wdata = '0;
    tick();
    chk("mis_keep_rdata", b.d_rdata, 32'hDEAD_BEEF);
    b.d_req = 1'b0;
    b.if_req = 1'b1; b.if_addr = 12'h002;
    #1 chk("mis_if_gnt", 32'(b.if_gnt), 32'h1);
    tick();
    chk("mis_if_ack", 32'(b.if_ack), 32'h1);
    chk("mis_if_err", 32'(b.if_err), 32'h1);
    chk("mis_if_rdata", b.if_rdata, 32'h0);

    // 6. Fetch alternating 0x000 / 0x004 at full throughput
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? 12'h000 : 12'h004;
      b.if_addr = a;
      #1 chk("ft_if_gnt", 32'(b.if_gnt), 32'h1);
      tick();
      chk("ft_if_ack", 32'(b.if_ack), 32'h1);
      chk("ft_if_rdata", b.if_rdata, (a == 12'h000) ? 32'h1111_0000 : 32'h2222_0004);
      chk("ft_if_err", 32'(b.if_err), 32'h0);
    end
    b.if_req = 1'b0;
    tick();

    // 3. Both ports held: D,D,D,D,IF repeating
    b.if_req = 1'b1; b.if_addr = 12'h004;
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 12'h010;
    for (int k = 0; k < 10; k++) begin
      exp_d = (k % 5) != 4;
      #1;
      chk("sv_d_gnt", 32'(b.d_gnt), 32'(exp_d));
      chk("sv_if_gnt", 32'(b.if_gnt), 32'(!exp_d));
      tick();
      chk("sv_d_ack", 32'(b.d_ack), 32'(exp_d));
      chk("sv_if_ack", 32'(b.if_ack), 32'(!exp_d));
      chk("sv_rdata", exp_d ? b.d_rdata : b.if_rdata,
          exp_d ? 32'hDEAD_BEEF : 32'h2222_0004);
    end
    b.if_req = 1'b0; b.d_req = 1'b0;
    tick();

    // 4. Zero limit: pure data priority
    z.if_req = 1'b1; z.if_addr = 12'h004;
    z.d_req = 1'b1; z.d_addr = 12'h010;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("z_d_gnt", 32'(z.d_gnt), 32'h1);
      chk("z_if_gnt", 32'(z.if_gnt), 32'h0);
      tick();
    end
    z.d_req = 1'b0;
    #1 chk("z_if_gnt_rel", 32'(z.if_gnt), 32'h1);
    tick();
    chk("z_if_ack", 32'(z.if_ack), 32'h1);
    z.if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
